// File: rtl/usb_ep_stream_reader.sv
// usb_ep_stream_reader
//
// Wishbone read master that drains one isochronous-OUT endpoint buffer per command
// from the USB core buffer memory into a small sample FIFO. The FIFO head is
// presented as a 16-bit stereo PCM sample on a valid/ready stream.
//
// Ports
//   clk_i, nrst_i             clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake, accepted only when idle
//   cmd_ptr_i, cmd_len_i      buffer byte pointer and byte length (low two bits ignored)
//   done_o, err_o             one-cycle pulses: buffer fully read / ack timeout
//   wb_*                      Wishbone master read port (stb and cyc identical)
//   smp_valid_o/smp_ready_i   sample stream handshake (first-word fall-through)
//   smp_left_o, smp_right_o   FIFO head word [15:0] and [31:16]
module usb_ep_stream_reader #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [16:0]       cmd_ptr_i,
  input  logic [13:0]       cmd_len_i,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  input  logic [31:0]       wb_data_i,
  input  logic              wb_ack_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  output logic              smp_valid_o,
  input  logic              smp_ready_i,
  output logic [15:0]       smp_left_o,
  output logic [15:0]       smp_right_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e        state_q, state_d;
  logic [16:0]   ptr_q, ptr_d;
  logic [11:0]   words_q, words_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          stb_q, stb_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push, pop, space_next;

  // Command byte-lane bits are don't-care.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd_ptr_i[1:0], cmd_len_i[1:0]};

  // stb is only ever high in StReq, so an ack with stb high is a completed read.
  assign push = stb_q & wb_ack_i;
  assign pop  = smp_valid_o & smp_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // stb is registered, so the decision to request uses next cycle's occupancy.
  assign space_next = (cnt_d < CW'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    words_d = words_q;
    tmo_d   = tmo_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          ptr_d   = {cmd_ptr_i[16:2], 2'b00};
          words_d = cmd_len_i[13:2];
          tmo_d   = '0;
          if (cmd_len_i[13:2] == 12'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StReq;
            stb_d   = space_next;
          end
        end
      end
      StReq: begin
        if (stb_q) begin
          if (wb_ack_i) begin
            ptr_d   = ptr_q + 17'd4;
            words_d = words_q - 12'd1;
            tmo_d   = '0;
            if (words_q == 12'd1) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StGap;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            // stb has now been high for TIMEOUT cycles without an ack.
            state_d = StIdle;
            err_d   = 1'b1;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
            stb_d = 1'b1;
          end
        end else begin
          // Waiting for FIFO space; the timeout does not run.
          tmo_d = '0;
          stb_d = space_next;
        end
      end
      StGap: begin
        state_d = StReq;
        stb_d   = space_next;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      words_q <= '0;
      tmo_q   <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wb_data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wb_addr_o   = ADDR_W'(ptr_q);
  assign wb_we_o     = 1'b0;
  assign wb_stb_o    = stb_q;
  assign wb_cyc_o    = stb_q;
  assign smp_valid_o = (cnt_q != '0);
  assign smp_left_o  = mem_q[rd_q][15:0];
  assign smp_right_o = mem_q[rd_q][31:16];

endmodule

// File: tb/tb_usb_ep_stream_reader.sv
// Self-checking bench for usb_ep_stream_reader: table of single-command vectors plus
// hand-written backpressure and mid-transfer reset sequences. The slave acks in the
// second cycle of each strobe and returns data derived from the offset into the buffer.
module tb_usb_ep_stream_reader;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [16:0] cmd_ptr_i;
  logic [13:0] cmd_len_i;
  logic        done_o;
  logic        err_o;
  logic [17:0] wb_addr_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        smp_valid_o;
  logic        smp_ready_i;
  logic [15:0] smp_left_o;
  logic [15:0] smp_right_o;

  usb_ep_stream_reader #(
    .ADDR_W    (18),
    .FIFO_DEPTH(8),
    .TIMEOUT   (255)
  ) dut (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_ptr_i  (cmd_ptr_i),
    .cmd_len_i  (cmd_len_i),
    .done_o     (done_o),
    .err_o      (err_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_i  (wb_data_i),
    .wb_ack_i   (wb_ack_i),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .smp_valid_o(smp_valid_o),
    .smp_ready_i(smp_ready_i),
    .smp_left_o (smp_left_o),
    .smp_right_o(smp_right_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Slave model.
  logic        ack_en;
  logic [16:0] base_ptr;

  function automatic logic [31:0] word_data(input logic [16:0] off);
    logic [15:0] idx;
    idx = {1'b0, off[16:2]};
    return {idx * 16'd2 + 16'd2, idx * 16'd2 + 16'd1};
  endfunction

  always @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) wb_ack_i <= 1'b0;
    else         wb_ack_i <= wb_stb_o && !wb_ack_i && ack_en;
  end

  assign wb_data_i = word_data(wb_addr_o[16:0] - base_ptr);

  // Monitors: completed bus reads and popped samples.
  logic [17:0] addr_q [$];
  logic [31:0] smp_q  [$];

  always @(posedge clk_i) begin
    if (wb_stb_o && wb_ack_i) addr_q.push_back(wb_addr_o);
    if (smp_valid_o && smp_ready_i) smp_q.push_back({smp_right_o, smp_left_o});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [16:0] ptr, input logic [13:0] len);
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_ptr_i   = ptr;
    cmd_len_i   = len;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // Returns the cycle (1 = first cycle after acceptance) where done/err is seen.
  task automatic wait_end(input int budget, output int cyc, output int stbc);
    cyc  = 1;
    stbc = wb_stb_o ? 1 : 0;
    while (!done_o && !err_o && cyc < budget) begin
      tick();
      cyc++;
      if (wb_stb_o) stbc++;
    end
  endtask

  // Compare captured addresses and samples from index offsets a0/s0.
  task automatic check_stream(input string tag, input logic [16:0] base, input int words,
                              input int a0, input int s0);
    logic [16:0] ea;
    logic [31:0] es;
    check({tag, " addr count"}, 32'(addr_q.size() - a0), 32'(words));
    check({tag, " sample count"}, 32'(smp_q.size() - s0), 32'(words));
    for (int k = 0; k < words; k++) begin
      ea = base + 17'(4 * k);
      es = {16'(2 * k + 2), 16'(2 * k + 1)};
      if (a0 + k < addr_q.size()) check({tag, " addr"}, 32'(addr_q[a0 + k]), {14'd0, 1'b0, ea});
      if (s0 + k < smp_q.size()) check({tag, " sample"}, smp_q[s0 + k], es);
    end
  endtask

  typedef struct {
    logic [16:0] ptr;
    logic [13:0] len;
    bit          ack;
    int          words;
    int          end_cyc;
    int          stb_cyc;
    bit          exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc, stbc, a0, s0, n;
    logic [16:0] base;

    vecs[0] = '{ptr: 17'h01000, len: 14'd16, ack: 1'b1, words: 4, end_cyc: 12, stb_cyc: 8,
                exp_err: 1'b0};
    vecs[1] = '{ptr: 17'h00200, len: 14'd3, ack: 1'b1, words: 0, end_cyc: 1, stb_cyc: 0,
                exp_err: 1'b0};
    vecs[2] = '{ptr: 17'h1FFFC, len: 14'd8, ack: 1'b1, words: 2, end_cyc: 6, stb_cyc: 4,
                exp_err: 1'b0};
    vecs[3] = '{ptr: 17'h00123, len: 14'd11, ack: 1'b1, words: 2, end_cyc: 6, stb_cyc: 4,
                exp_err: 1'b0};
    vecs[4] = '{ptr: 17'h00400, len: 14'd16, ack: 1'b0, words: 0, end_cyc: 256, stb_cyc: 255,
                exp_err: 1'b1};

    nrst_i      = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_ptr_i   = '0;
    cmd_len_i   = '0;
    smp_ready_i = 1'b1;
    ack_en      = 1'b1;
    base_ptr    = '0;
    #1 nrst_i = 1'b0;
    #2;
    check("rst cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst stb", 32'(wb_stb_o), 32'd0);
    check("rst cyc", 32'(wb_cyc_o), 32'd0);
    check("rst we", 32'(wb_we_o), 32'd0);
    check("rst addr", 32'(wb_addr_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    check("rst smp_valid", 32'(smp_valid_o), 32'd0);
    check("rst left", 32'(smp_left_o), 32'd0);
    check("rst right", 32'(smp_right_o), 32'd0);
    @(negedge clk_i);
    nrst_i = 1'b1;
    tick();

    // Table-driven single commands with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      base        = vecs[i].ptr & 17'h1FFFC;
      base_ptr    = base;
      ack_en      = vecs[i].ack;
      smp_ready_i = 1'b1;
      a0 = addr_q.size();
      s0 = smp_q.size();
      check("vec idle ready", 32'(cmd_ready_o), 32'd1);
      send_cmd(vecs[i].ptr, vecs[i].len);
      wait_end(2000, cyc, stbc);
      check("vec end cycle", 32'(cyc), 32'(vecs[i].end_cyc));
      check("vec stb cycles", 32'(stbc), 32'(vecs[i].stb_cyc));
      check("vec done", 32'(done_o), 32'(!vecs[i].exp_err));
      check("vec err", 32'(err_o), 32'(vecs[i].exp_err));
      tick();
      check("vec done pulse", 32'(done_o), 32'd0);
      check("vec err pulse", 32'(err_o), 32'd0);
      check("vec ready after", 32'(cmd_ready_o), 32'd1);
      check("vec stb after", 32'(wb_stb_o), 32'd0);
      repeat (4) tick();
      check("vec fifo drained", 32'(smp_valid_o), 32'd0);
      check_stream("vec", base, vecs[i].words, a0, s0);
    end

    // Backpressure: FIFO fills after 8 words, stb stays low until the consumer drains.
    ack_en      = 1'b1;
    base_ptr    = 17'h00000;
    smp_ready_i = 1'b0;
    a0 = addr_q.size();
    s0 = smp_q.size();
    send_cmd(17'h00000, 14'd64);
    repeat (60) tick();
    check("bp acks while full", 32'(addr_q.size() - a0), 32'd8);
    check("bp stb held low", 32'(wb_stb_o), 32'd0);
    check("bp busy", 32'(cmd_ready_o), 32'd0);
    check("bp valid", 32'(smp_valid_o), 32'd1);
    check("bp head left", 32'(smp_left_o), 32'd1);
    check("bp head right", 32'(smp_right_o), 32'd2);
    smp_ready_i = 1'b1;
    wait_end(1000, cyc, stbc);
    check("bp done", 32'(done_o), 32'd1);
    repeat (12) tick();
    check_stream("bp", 17'h00000, 16, a0, s0);

    // Reset mid-transfer with three words buffered.
    base_ptr    = 17'h00800;
    smp_ready_i = 1'b0;
    a0 = addr_q.size();
    send_cmd(17'h00800, 14'd64);
    n = 0;
    while (addr_q.size() - a0 < 3 && n < 100) begin
      tick();
      n++;
    end
    check("mid words before reset", 32'(addr_q.size() - a0), 32'd3);
    check("mid valid before reset", 32'(smp_valid_o), 32'd1);
    #2 nrst_i = 1'b0;
    #1;
    check("mid rst stb", 32'(wb_stb_o), 32'd0);
    check("mid rst cyc", 32'(wb_cyc_o), 32'd0);
    check("mid rst ready", 32'(cmd_ready_o), 32'd1);
    check("mid rst addr", 32'(wb_addr_o), 32'd0);
    check("mid rst valid", 32'(smp_valid_o), 32'd0);
    check("mid rst left", 32'(smp_left_o), 32'd0);
    check("mid rst right", 32'(smp_right_o), 32'd0);
    @(negedge clk_i);
    nrst_i      = 1'b1;
    smp_ready_i = 1'b1;
    s0 = smp_q.size();
    send_cmd(17'h00040, 14'd2);
    check("post rst zero-len done", 32'(done_o), 32'd1);
    repeat (3) tick();
    check("post rst no samples", 32'(smp_q.size() - s0), 32'd0);
    check("post rst stb", 32'(wb_stb_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_ep_stream_reader.md
# usb_ep_stream_reader

Wishbone master that drains an isochronous-OUT endpoint buffer from the USB function core's buffer memory into a small sample FIFO and presents the data as 16-bit stereo PCM samples on a valid/ready stream. It sits beside the function controller on the USB core's Wishbone slave port, downstream of the endpoint buffers. It is started with one command per filled buffer: byte pointer and length. The audio output path consumes its sample stream.

## Interface
- ADDR_W, 18, Wishbone address width (equals `USBF_UFC_HADR`+1); MSB selects register file (1) or buffer memory (0).
- FIFO_DEPTH, 8, sample FIFO depth in 32-bit words; power of two, ≥2.
- TIMEOUT, 255, maximum cycles to wait for wb_ack_i per access.

- clk_i  in  1  single clock; all logic rising-edge.
- nrst_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high in IDLE only; command accepted on valid&ready.
- cmd_ptr_i  in  17  buffer byte pointer; bits [1:0] ignored, treated as 0.
- cmd_len_i  in  14  buffer length in bytes; bits [1:0] ignored; word count N = cmd_len_i[13:2].
- done_o  out  1  one-cycle pulse: all N words captured.
- err_o  out  1  one-cycle pulse: ack timeout, transfer aborted.
- wb_addr_o  out  ADDR_W  {1'b0, word-aligned byte address}.
- wb_data_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_we_o  out  1  constant 0.
- wb_stb_o, wb_cyc_o  out  1  identical, registered.
- smp_valid_o  out  1  FIFO not empty.
- smp_ready_i  in  1  consumer accepts sample.
- smp_left_o  out  16  FIFO head word [15:0].
- smp_right_o  out  16  FIFO head word [31:16].

## Operation
- States: IDLE, REQ, GAP.
- IDLE: cmd_ready_o=1. On accept, latch ptr (bits [1:0] cleared) and N. If N=0: pulse done_o next cycle, stay IDLE, no bus cycle. Else go to REQ.
- REQ: drive stb/cyc while FIFO count < FIFO_DEPTH. If the FIFO is full, hold stb/cyc low and keep the timeout counter at 0. On wb_ack_i:
  - push wb_data_i;
  - ptr += 4, wrapping mod 2^17;
  - N -= 1;
  - drop stb/cyc;
  - go to GAP, or to IDLE with done_o if N reaches 0.
- GAP: exactly one idle bus cycle, then REQ.
- Timeout: the counter runs while stb is high. When it reaches TIMEOUT without an ack, drop stb/cyc, pulse err_o, and go to IDLE. Words already pushed stay in the FIFO.
- FIFO: standard circular buffer with count of width log2(FIFO_DEPTH)+1.
  - Pop on smp_valid_o & smp_ready_i.
  - Simultaneous push and pop leaves count unchanged.
  - A push never occurs when full, guaranteed by REQ gating.
- cmd_valid_i outside IDLE is ignored; no queuing.
- Asynchronous reset mid-transfer: bus released, FIFO emptied, command discarded.

## Timing
- Reset values:
  - cmd_ready_o=1;
  - wb_stb_o, wb_cyc_o, wb_we_o = 0;
  - wb_addr_o=0;
  - done_o=0, err_o=0;
  - smp_valid_o=0;
  - smp_left_o=0, smp_right_o=0 (the FIFO head reads 0 after reset).
- Command accepted at edge k: stb/cyc high from cycle k+1, with wb_addr_o valid in the same cycle.
- Ack sampled at edge a:
  - data enters the FIFO at edge a;
  - smp_valid_o is high from cycle a+1;
  - stb is low in cycle a+1 (GAP);
  - stb is high again in cycle a+2 if space remains.
- Zero-wait slave: one word every 2 cycles.
- Final ack at edge a: done_o=1 and cmd_ready_o=1 in cycle a+1.
- err_o is asserted in the cycle after stb has been high for TIMEOUT cycles.
- Sample output is FWFT: the head is valid combinationally from FIFO storage, with no extra latency.

## Test plan
- ptr=0x01000, len=16, slave acks 1 cycle after stb, words 0x0002_0001..0x0008_0007, smp_ready_i=1:
  - expect addresses 0x00, 0x04, 0x08, 0x0C (+0x01000) with MSB 0;
  - samples L/R = 1/2, 3/4, 5/6, 7/8;
  - one done_o pulse.
- len=64 (N=16), smp_ready_i=0: stb stops after 8 acks (FIFO full). Releasing ready resumes transfers; all 16 words arrive in order.
- Slave never acks: err_o at TIMEOUT=255, stb low, cmd_ready_o=1, FIFO unchanged.
- len=3: done_o next cycle, no stb.
- ptr=0x1FFFC, len=8: second address wraps to 0x00000.
- Assert nrst_i low mid-transfer with 3 words in FIFO: outputs return to reset values immediately; smp_valid_o=0.
